seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Runtime-programmable serial pattern detector, the successor to the fixed 3-bit detectors.
- Pattern up to MAX_LEN bits; length set at load time.
- Overlapping or non-overlapping matching.
- Sample-enable gating and configuration error flag.
- Sits on a serial data line (xin); raises a one-cycle pulse on y per detected match.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN+1), width of length field (derived, not overridden)
CNT_W, 16, match counter width (optional feature only)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
xin  input  1  serial data bit, sampled when en=1
en  input  1  sample enable; one bit consumed per enabled cycle
load  input  1  one-cycle strobe: capture pat, pat_len, overlap
pat  input  MAX_LEN  pattern; pat[pat_len-1] is the first bit received, pat[0] the last
pat_len  input  LEN_W  pattern length, legal 1..MAX_LEN
overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after match
y  output  1  registered match pulse
armed  output  1  high in RUN state
cfg_err  output  1  sticky; set by load with illegal pat_len
match_cnt  output  CNT_W  saturating match count (SEQDET_MATCH_CNT_EN only)

Behaviour:
- Reset (async, active-high) clears everything. State=IDLE; y=0, armed=0, cfg_err=0, match_cnt=0. History, fill count and latched config regs are cleared.
- FSM states: IDLE, RUN.
  - IDLE: xin/en ignored; y=0. load with pat_len in 1..MAX_LEN -> RUN, cfg_err<=0. load with pat_len=0 or >MAX_LEN -> stay IDLE, cfg_err<=1.
  - RUN: load re-captures config; same legality rule applies; an illegal load returns to IDLE with cfg_err=1.
- Every load clears history and the fill counter and forces y<=0. xin is not sampled in the load cycle. load has priority over en.
- In RUN with en=1:
  - hist <= {hist[MAX_LEN-2:0], xin}.
  - fill <= min(fill+1, MAX_LEN).
  - match = (fill+1 >= len_r) and (low len_r bits of new hist == low len_r bits of pat_r); unused pattern bits are don't-care.
  - y <= match, so y is high exactly in the cycle after the edge that sampled the final pattern bit (latency 1).
- Overlap: overlap_r=1 keeps history on match, so a suffix may start the next match. overlap_r=0 sets fill<=0 on match, and the next match needs len_r fresh bits.
- en=0 in RUN: hist and fill held; y<=0. Gaps do not break partial matches.
- len_r=1: every enabled bit equal to pat_r[0] pulses y, including back-to-back pulses.
- Consecutive matches produce y high on consecutive cycles. No pulse stretching.
- overlap, pat and pat_len are used only as latched at load; changes between loads have no effect.

Optional Feature:
SEQDET_MATCH_CNT_EN
- Defined: match_cnt port present. It increments on every cycle where y is set, saturates at all-ones, and clears on reset or any load.
- Undefined: port and counter absent. Behaviour is otherwise identical.

Test Plan:
- Reset check: assert reset mid-stream while y=1 -> y, armed, cfg_err drop to 0 immediately without a clock; after release, xin is ignored until load.
- Overlap: load pat=8'b00000101, len=3, overlap=1; stream 1,0,1,0,1 with en=1 -> y high after the 3rd and 5th samples only.
- Non-overlap: same pattern with overlap=0; stream 1,0,1,0,1,0,1 -> y after 3rd and 7th samples only.
- Full length and enable gaps: len=8, pat=8'hA5; stream 1,0,1,0,0,1,0,1 with en=0 gaps of 3 cycles inserted mid-pattern -> exactly one y pulse, one cycle after the last bit.
- Config errors: load len=0 -> cfg_err=1, armed=0, no y for any stream; then load len=9 (MAX_LEN=8) -> cfg_err stays 1; then a legal load -> cfg_err=0, armed=1. Simultaneous load and en: the bit in that cycle is not counted.
- SEQDET_MATCH_CNT_EN with CNT_W=2: pattern len=1, pat[0]=1; 5 consecutive 1s -> match_cnt 1,2,3,3,3; then load -> match_cnt=0.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with overlap control
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   xin, en           - serial data bit, consumed only on cycles with en=1
//   load              - strobe capturing pat, pat_len and overlap
//   pat, pat_len      - pattern (pat[pat_len-1] arrives first) and its length (1..MAX_LEN)
//   overlap           - 1 keeps history after a match, 0 restarts the fill
//   y                 - one-cycle registered match pulse
//   armed             - high while running with a legal configuration
//   cfg_err           - set by a load with an illegal length, cleared by a legal load
//   match_cnt         - saturating match counter, present only with SEQDET_MATCH_CNT_EN
module seq_detector_param #(
    parameter int MAX_LEN = 8,
`ifdef SEQDET_MATCH_CNT_EN
    parameter int CNT_W = 16,
`endif
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               xin,
    input  logic               en,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               y,
    output logic               armed,
    output logic               cfg_err
`ifdef SEQDET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [LEN_W:0] MAXL = (LEN_W + 1)'(MAX_LEN);

    state_t             state, state_nx;
    logic [MAX_LEN-1:0] hist, pat_r, hist_nx, mask;
    logic [LEN_W-1:0]   len_r, fill, fill_nx;
    logic [LEN_W:0]     fill_inc;
    logic               ovl_r, legal, match;

    assign legal    = (pat_len != '0) && ({1'b0, pat_len} <= MAXL);
    assign hist_nx  = {hist[MAX_LEN-2:0], xin};
    // Only the low len_r bits take part; a shift by MAX_LEN yields an all-ones mask
    assign mask     = ~({MAX_LEN{1'b1}} << len_r);
    // One bit wider so fill+1 cannot wrap when MAX_LEN+1 is a power of two
    assign fill_inc = {1'b0, fill} + (LEN_W + 1)'(1);
    assign match    = (fill_inc >= {1'b0, len_r}) && (((hist_nx ^ pat_r) & mask) == '0);
    assign fill_nx  = (match && !ovl_r) ? '0 : (fill_inc > MAXL ? MAXL[LEN_W-1:0] : fill_inc[LEN_W-1:0]);
    assign armed    = (state == RUN);

    always_comb begin
        state_nx = state;
        if (load) state_nx = legal ? RUN : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist    <= '0;
            fill    <= '0;
            pat_r   <= '0;
            len_r   <= '0;
            ovl_r   <= 1'b0;
            y       <= 1'b0;
            cfg_err <= 1'b0;
        end else if (load) begin
            hist    <= '0;
            fill    <= '0;
            pat_r   <= pat;
            len_r   <= pat_len;
            ovl_r   <= overlap;
            y       <= 1'b0;
            cfg_err <= !legal;
        end else if (state == RUN && en) begin
            hist    <= hist_nx;
            fill    <= fill_nx;
            y       <= match;
        end else begin
            y       <= 1'b0;
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    // Counts alongside y so the count and the pulse appear on the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) match_cnt <= '0;
        else if (load) match_cnt <= '0;
        else if (state == RUN && en && match && !(&match_cnt)) match_cnt <= match_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed scoreboard bench for seq_detector_param
module tb_seq_detector_param;
    logic       clk = 1'b0, reset = 1'b0, xin = 1'b0, en = 1'b0, load = 1'b0, overlap = 1'b0;
    logic [7:0] pat = '0;
    logic [3:0] pat_len = '0;
    logic       y, armed, cfg_err;
`ifdef SEQDET_MATCH_CNT_EN
    logic [1:0] match_cnt;
`endif
    int   checks = 0, errors = 0;
    logic exp_q[$];

    seq_detector_param #(
        .MAX_LEN(8)
`ifdef SEQDET_MATCH_CNT_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk(clk), .reset(reset), .xin(xin), .en(en), .load(load),
        .pat(pat), .pat_len(pat_len), .overlap(overlap),
        .y(y), .armed(armed), .cfg_err(cfg_err)
`ifdef SEQDET_MATCH_CNT_EN
        , .match_cnt(match_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle; the expected y for the following edge goes to the scoreboard
    task automatic step(input logic x, input logic e, input logic ey);
        xin = x; en = e; load = 1'b0;
        exp_q.push_back(ey);
        @(posedge clk); #1;
        chk("y", {31'b0, y}, {31'b0, exp_q.pop_front()});
    endtask

    // Load with en=1 and xin=1 so the load cycle also proves the bit is not consumed
    task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o,
                           input logic ea, input logic ee);
        pat = p; pat_len = l; overlap = o; load = 1'b1; en = 1'b1; xin = 1'b1;
        exp_q.push_back(1'b0);
        @(posedge clk); #1;
        load = 1'b0; en = 1'b0;
        chk("load_y", {31'b0, y}, {31'b0, exp_q.pop_front()});
        chk("armed", {31'b0, armed}, {31'b0, ea});
        chk("cfg_err", {31'b0, cfg_err}, {31'b0, ee});
`ifdef SEQDET_MATCH_CNT_EN
        chk("cnt_load", {30'b0, match_cnt}, 32'd0);
`endif
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        chk("rst_y", {31'b0, y}, 32'd0);
        chk("rst_armed", {31'b0, armed}, 32'd0);
        chk("rst_cfg_err", {31'b0, cfg_err}, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        chk("idle_armed", {31'b0, armed}, 32'd0);

        do_load(8'b0000_0101, 4'd3, 1'b1, 1'b1, 1'b0);
        pat = '0; pat_len = 4'd1; overlap = 1'b0;
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 1); step(0, 1, 0); step(1, 1, 1);

        do_load(8'b0000_0101, 4'd3, 1'b0, 1'b1, 1'b0);
        pat = 8'hFF; overlap = 1'b1;
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 1); step(0, 1, 0);
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 1);

        do_load(8'hA5, 4'd8, 1'b1, 1'b1, 1'b0);
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(0, 1, 0);
        step(1, 0, 0); step(0, 0, 0); step(1, 0, 0);
        step(0, 1, 0); step(1, 1, 0); step(0, 1, 0); step(1, 1, 1);
        step(1, 0, 0);

        do_load(8'b0000_0001, 4'd1, 1'b1, 1'b1, 1'b0);
        step(1, 1, 1); step(1, 1, 1); step(0, 1, 0); step(1, 1, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_y", {31'b0, y}, 32'd0);
        chk("async_armed", {31'b0, armed}, 32'd0);
        chk("async_cfg_err", {31'b0, cfg_err}, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        step(1, 1, 0); step(1, 1, 0);
        chk("post_rst_armed", {31'b0, armed}, 32'd0);

        do_load(8'b0000_0001, 4'd0, 1'b1, 1'b0, 1'b1);
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 0);
        do_load(8'b0000_0001, 4'd9, 1'b1, 1'b0, 1'b1);
        step(1, 1, 0);
        do_load(8'b0000_0011, 4'd2, 1'b1, 1'b1, 1'b0);
        step(1, 1, 0); step(1, 1, 1); step(1, 0, 0);

`ifdef SEQDET_MATCH_CNT_EN
        do_load(8'b0000_0001, 4'd1, 1'b1, 1'b1, 1'b0);
        step(1, 1, 1); chk("cnt1", {30'b0, match_cnt}, 32'd1);
        step(1, 1, 1); chk("cnt2", {30'b0, match_cnt}, 32'd2);
        step(1, 1, 1); chk("cnt3", {30'b0, match_cnt}, 32'd3);
        step(1, 1, 1); chk("cnt4", {30'b0, match_cnt}, 32'd3);
        step(1, 1, 1); chk("cnt5", {30'b0, match_cnt}, 32'd3);
        do_load(8'b0000_0001, 4'd1, 1'b1, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
